// File: rtl/uart_rx_char_queue.sv
// ---------------------------------------------------------------------------
// uart_rx_char_queue
//
// Receive-side character queue that sits between the UART receiver and the
// text driver. Every received byte is captured on its valid strobe into a
// small FIFO. A four-state dequeue FSM (IDLE, LOAD, WRITE, HOLD) hands the
// characters to the text driver one at a time. After each write strobe it
// inserts GAP idle cycles so the driver's framebuffer update always has time
// to finish.
//
// Parameters:
//   DEPTH     FIFO entries, power of two, 4..256
//   GAP       idle cycles inserted after each CHAR_WE pulse, 0..65535
//
// Ports:
//   CLK_50MHz  in   sole clock, rising edge
//   RESET      in   synchronous active-high reset
//   RX_DATA    in   received byte, sampled when RX_VALID=1
//   RX_VALID   in   one-cycle receive strobe (already synchronous)
//   BUSY       in   text driver busy; holds the FSM in IDLE
//   OVF_CLR    in   clears OVERFLOW
//   CHAR       out  character to the text driver (held between strobes)
//   CHAR_WE    out  one-cycle write strobe for CHAR
//   COUNT      out  number of entries held, 0..DEPTH
//   EMPTY      out  COUNT == 0
//   FULL       out  COUNT == DEPTH
//   OVERFLOW   out  sticky, set when a byte is dropped
//
// Optional feature, macro RX_CTRL_MAP_EN:
//   When this macro is defined, bytes are mapped at enqueue: CR becomes LF,
//   DEL becomes BS, and NUL is discarded without affecting OVERFLOW.
//   When it is undefined, bytes are stored unmodified.
// ---------------------------------------------------------------------------
module uart_rx_char_queue #(
  parameter int DEPTH = 16,
  parameter int GAP   = 64
) (
  input  logic                     CLK_50MHz,
  input  logic                     RESET,
  input  logic [7:0]               RX_DATA,
  input  logic                     RX_VALID,
  input  logic                     BUSY,
  input  logic                     OVF_CLR,
  output logic [7:0]               CHAR,
  output logic                     CHAR_WE,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic                     OVERFLOW
);

  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthVal = CntW'(DEPTH);
  localparam logic [15:0]     GapVal   = 16'(GAP);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     gap_q, gap_d;
  logic [7:0]      char_q, char_d;
  logic [PtrW-1:0] wrPtr_q, wrPtr_d;
  logic [PtrW-1:0] rdPtr_q, rdPtr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [DEPTH];

  logic [7:0]      mapData;
  logic            mapKeep;
  logic            isFull;
  logic            isEmpty;
  logic            push;
  logic            drop;
  logic            pop;

  assign isFull  = (count_q == DepthVal);
  assign isEmpty = (count_q == '0);

  // Optional control-character translation applied before the byte is
  // stored. mapKeep=0 makes the byte vanish entirely, so a discarded NUL
  // can never count as an overflow drop.
  always_comb begin
    mapData = RX_DATA;
    mapKeep = 1'b1;
`ifdef RX_CTRL_MAP_EN
    case (RX_DATA)
      8'h0D:   mapData = 8'h0A;
      8'h7F:   mapData = 8'h08;
      8'h00:   mapKeep = 1'b0;
      default: mapData = RX_DATA;
    endcase
`endif
  end

  // FULL is taken from the registered count, i.e. before any pop in the
  // same cycle. A pop in that cycle therefore cannot rescue a byte that
  // arrives while the queue is full.
  assign push = RX_VALID & mapKeep & ~isFull;
  assign drop = RX_VALID & mapKeep & isFull;

  // Dequeue FSM next-state logic and the datapath updates it controls.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    char_d  = char_q;
    pop     = 1'b0;
    CHAR_WE = 1'b0;
    case (state_q)
      IDLE: begin
        if (!isEmpty && !BUSY) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        pop     = 1'b1;
        char_d  = mem_q[rdPtr_q];
        state_d = WRITE;
      end
      WRITE: begin
        CHAR_WE = 1'b1;
        gap_d   = GapVal;
        state_d = (GapVal == 16'd0) ? IDLE : HOLD;
      end
      HOLD: begin
        // The counter holds GAP on entry, so IDLE follows after exactly
        // GAP cycles in HOLD.
        gap_d = gap_q - 16'd1;
        if (gap_q <= 16'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer and count bookkeeping. The pointers wrap naturally because DEPTH
  // is a power of two. The count is kept on its own rather than derived
  // from the pointers, which lets it tell a full queue from an empty one.
  always_comb begin
    wrPtr_d = push ? (wrPtr_q + PtrW'(1)) : wrPtr_q;
    rdPtr_d = pop  ? (rdPtr_q + PtrW'(1)) : rdPtr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // A drop takes priority over a clear in the same cycle.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control and status registers, flushed by the synchronous reset.
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      state_q <= IDLE;
      gap_q   <= '0;
      char_q  <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      char_q  <= char_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array. It has no reset because stale contents are never read:
  // the count gates every read.
  always_ff @(posedge CLK_50MHz) begin
    if (push) begin
      mem_q[wrPtr_q] <= mapData;
    end
  end

  assign CHAR     = char_q;
  assign COUNT    = count_q;
  assign EMPTY    = isEmpty;
  assign FULL     = isFull;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_uart_rx_char_queue.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_char_queue
//
// Self-checking bench for uart_rx_char_queue (DEPTH=16, GAP=4).
//
// The reference model is a queue of accepted bytes plus timing arithmetic:
// - A character may leave at the earliest 2 edges after it arrives.
// - Consecutive characters leave at least GAP+3 edges apart.
// - A character never leaves while BUSY holds the idle queue.
// - A byte is dropped if the queue is already full before the edge.
// Every cycle the bench compares all outputs against this model. Directed
// scenarios then add explicit timing and ordering checks.
// ---------------------------------------------------------------------------
module tb_uart_rx_char_queue;

  localparam int DEPTH = 16;
  localparam int GAP   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rxData;
  logic       rxValid;
  logic       busy;
  logic       ovfClr;
  logic [7:0] charOut;
  logic       charWe;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;

  uart_rx_char_queue #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .CLK_50MHz (clk),
    .RESET     (reset),
    .RX_DATA   (rxData),
    .RX_VALID  (rxValid),
    .BUSY      (busy),
    .OVF_CLR   (ovfClr),
    .CHAR      (charOut),
    .CHAR_WE   (charWe),
    .COUNT     (count),
    .EMPTY     (empty),
    .FULL      (full),
    .OVERFLOW  (overflow)
  );

  always #10 clk = ~clk;

  int numChecks = 0;
  int numErrors = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         edgeNo     = 0;
  int         lastW      = -100;
  bit         popPending = 1'b0;
  int         popEdge    = 0;
  logic [7:0] mChar      = 8'h00;
  bit         mWe        = 1'b0;
  bit         mOvf       = 1'b0;

  // Observation log used by the directed scenarios
  int         stimCycle = 0;
  int         weTimes[$];
  logic [7:0] weChars[$];
  int         peak = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, stimCycle);
    end
  endtask

  // Advance the model by one clock edge, using the inputs sampled there.
  task automatic modelStep(input bit rst, input bit vld, input logic [7:0] d,
                           input bit bsy, input bit clr);
    int         cntPre;
    bit         keep;
    logic [7:0] md;
    bit         accept;
    bit         drop;
    edgeNo++;
    if (rst) begin
      mq.delete();
      popPending = 1'b0;
      lastW      = -100;
      mChar      = 8'h00;
      mWe        = 1'b0;
      mOvf       = 1'b0;
    end else begin
      cntPre = mq.size();
      mWe    = 1'b0;
      if (popPending && popEdge == edgeNo) begin
        mChar      = mq.pop_front();
        mWe        = 1'b1;
        popPending = 1'b0;
      end
      md   = d;
      keep = 1'b1;
`ifdef RX_CTRL_MAP_EN
      if (d == 8'h0D) md = 8'h0A;
      if (d == 8'h7F) md = 8'h08;
      if (d == 8'h00) keep = 1'b0;
`endif
      accept = vld && keep && (cntPre < DEPTH);
      drop   = vld && keep && (cntPre == DEPTH);
      if (accept) mq.push_back(md);
      if (drop) mOvf = 1'b1;
      else if (clr) mOvf = 1'b0;
      if (!popPending && !mWe && (edgeNo >= lastW + GAP + 2) && cntPre > 0 && !bsy) begin
        popPending = 1'b1;
        popEdge    = edgeNo + 1;
        lastW      = edgeNo + 1;
      end
    end
  endtask

  // One clock cycle: drive the inputs, step the model at the edge, then
  // compare every output on the falling edge.
  task automatic applyStimulus(input bit rst, input bit vld, input logic [7:0] d,
                               input bit bsy, input bit clr);
    reset   = rst;
    rxValid = vld;
    rxData  = d;
    busy    = bsy;
    ovfClr  = clr;
    @(posedge clk);
    modelStep(rst, vld, d, bsy, clr);
    @(negedge clk);
    stimCycle++;
    checkOutput("COUNT",    32'(count),    32'(mq.size()));
    checkOutput("EMPTY",    32'(empty),    32'(mq.size() == 0));
    checkOutput("FULL",     32'(full),     32'(mq.size() == DEPTH));
    checkOutput("OVERFLOW", 32'(overflow), 32'(mOvf));
    checkOutput("CHAR_WE",  32'(charWe),   32'(mWe));
    checkOutput("CHAR",     32'(charOut),  32'(mChar));
    if (charWe === 1'b1) begin
      weTimes.push_back(stimCycle);
      weChars.push_back(charOut);
    end
    if (int'(count) > peak) peak = int'(count);
  endtask

  task automatic idleCycles(input int n, input bit bsy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00, bsy, 1'b0);
  endtask

  task automatic clearLog();
    weTimes.delete();
    weChars.delete();
    peak = 0;
  endtask

  logic [7:0] expMap[$];
  int         pushCycle;
  int         weCount;
  bit         randBusy;

  initial begin
    reset   = 1'b1;
    rxValid = 1'b0;
    rxData  = 8'h00;
    busy    = 1'b0;
    ovfClr  = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rstCount", 32'(count), 32'd0);
    checkOutput("rstEmpty", 32'(empty), 32'd1);
    checkOutput("rstChar",  32'(charOut), 32'h00);
    idleCycles(3, 1'b0);

    // Single byte: strobe exactly two edges after the sample
    clearLog();
    applyStimulus(1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
    pushCycle = stimCycle;
    idleCycles(12, 1'b0);
    checkOutput("singlePulses", 32'(weTimes.size()), 32'd1);
    checkOutput("singleLatency", 32'(weTimes.size() > 0 ? weTimes[0] - pushCycle : -1), 32'd2);
    checkOutput("singleChar", 32'(weChars.size() > 0 ? weChars[0] : 8'hFF), 32'h41);
    checkOutput("singleEndCount", 32'(count), 32'd0);
    checkOutput("singleEndEmpty", 32'(empty), 32'd1);

    // Burst of five back-to-back bytes
    clearLog();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    idleCycles(45, 1'b0);
    checkOutput("burstPulses", 32'(weTimes.size()), 32'd5);
    checkOutput("burstPeak", 32'(peak), 32'd4);
    for (int i = 0; i < 5; i++)
      checkOutput("burstChar", 32'(i < weChars.size() ? weChars[i] : 8'hFF), 32'(8'h30 + i));
    for (int i = 0; i < 4; i++)
      checkOutput("burstSpacing", 32'(i + 1 < weTimes.size() ? weTimes[i+1] - weTimes[i] : -1), 32'(GAP + 3));

    // Overflow while the driver is busy; the 18th push also asserts OVF_CLR
    // to show that the drop wins.
    clearLog();
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
    checkOutput("ovfFullBefore", 32'(full), 32'd1);
    checkOutput("ovfFlagBefore", 32'(overflow), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h60, 1'b1, 1'b0);
    checkOutput("ovfFull", 32'(full), 32'd1);
    checkOutput("ovfCount", 32'(count), 32'd16);
    checkOutput("ovfFlag", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'h61, 1'b1, 1'b1);
    checkOutput("ovfDropBeatsClr", 32'(overflow), 32'd1);
    idleCycles(4, 1'b1);
    checkOutput("ovfBusyNoDrain", 32'(weTimes.size()), 32'd0);
    idleCycles(16 * (GAP + 3) + 20, 1'b0);
    checkOutput("ovfDrained", 32'(weTimes.size()), 32'd16);
    checkOutput("ovfLastChar", 32'(weChars.size() == 16 ? weChars[15] : 8'hFF), 32'h5F);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovfCleared", 32'(overflow), 32'd0);

    // Reset asserted during HOLD with bytes still queued
    clearLog();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    weCount = 0;
    for (int i = 0; i < 20 && weTimes.size() == 0; i++) idleCycles(1, 1'b0);
    checkOutput("rstMidFirstWe", 32'(weTimes.size()), 32'd1);
    idleCycles(1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    weCount = weTimes.size();
    idleCycles(30, 1'b0);
    checkOutput("rstMidNoWe", 32'(weTimes.size() - weCount), 32'd0);
    checkOutput("rstMidCount", 32'(count), 32'd0);
    checkOutput("rstMidChar", 32'(charOut), 32'h00);

    // Control-character mapping
    clearLog();
    applyStimulus(1'b0, 1'b1, 8'h0D, 1'b0, 1'b0);
    idleCycles(10, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    idleCycles(10, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h7F, 1'b0, 1'b0);
    idleCycles(15, 1'b0);
`ifdef RX_CTRL_MAP_EN
    expMap = '{8'h0A, 8'h08};
`else
    expMap = '{8'h0D, 8'h00, 8'h7F};
`endif
    checkOutput("mapPulses", 32'(weChars.size()), 32'(expMap.size()));
    foreach (expMap[i])
      checkOutput("mapChar", 32'(i < weChars.size() ? weChars[i] : 8'hFF), 32'(expMap[i]));

    // Randomised traffic against the model
    randBusy = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 40) == 0) randBusy = ~randBusy;
      applyStimulus($urandom_range(0, 599) == 0,
                    $urandom_range(0, 3) == 0,
                    8'($urandom),
                    randBusy,
                    $urandom_range(0, 31) == 0);
    end
    idleCycles(DEPTH * (GAP + 3) + 10, 1'b0);
    checkOutput("randDrained", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
